// File: rtl/alu_pkg.sv
// alu_pkg: shared types and defaults for the sequential ALU.
//   alu_op_t    - 4-bit operation codes
//   alu_state_t - handshake FSM states
//   ALU_WIDTH   - default datapath width
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_MULT = 4'b1000,
    OP_DIVU = 4'b1001,
    OP_NOR  = 4'b1100,
    OP_SLL  = 4'b1110,
    OP_SRL  = 4'b1111
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alu_state_t;

endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative unsigned multiply (shift-add) / restoring divide,
// one bit per cycle, sharing a single 2*WIDTH accumulator.
//   clk, reset - clock, async active-high reset
//   start      - load a/b/mode and begin WIDTH iterations
//   mode       - 0: multiply, 1: divide
//   a, b       - multiplicand/multiplier or dividend/divisor
//   done       - high during the final iteration cycle
//   lo, hi     - final values (valid while done): product low/high or
//                quotient/remainder
module seq_muldiv #(
  parameter int WIDTH = 32,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam logic [SW:0] CNT_INIT = (SW+1)'(WIDTH);

  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, remaining dividend / quotient bits}.
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   b_r;
  logic               mode_r;
  logic [SW:0]        cnt;

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_rem;

  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_r} : '0);
    div_rem = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    if (!mode_r) begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end else if (div_rem >= {1'b0, b_r}) begin
      // Divisor of zero always takes this branch: quotient ends all ones and
      // the dividend shifts unchanged into the remainder half.
      acc_nxt = {WIDTH'(div_rem - {1'b0, b_r}), acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      b_r    <= '0;
      mode_r <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= {{WIDTH{1'b0}}, a};
      b_r    <= b;
      mode_r <= mode;
      cnt    <= CNT_INIT;
    end else if (cnt != '0) begin
      acc <= acc_nxt;
      cnt <= cnt - 1'b1;
    end
  end

  // Results are taken from the final iteration's next-state so the top can
  // register them on the same edge the counter expires.
  assign done = (cnt == (SW+1)'(1));
  assign lo   = acc_nxt[WIDTH-1:0];
  assign hi   = acc_nxt[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/seq_alu.sv
// seq_alu: EX-stage ALU with single-cycle logic/arith/shift ops and
// iterative MULT/DIVU behind a valid/ready handshake.
//   clk, reset          - clock, async active-high reset
//   in_valid, in_ready  - request handshake (ready low while MULT/DIVU runs)
//   alu_ctrl            - operation code (alu_op_t)
//   rs, rt, shamt       - operands and shift amount
//   out_valid           - one-cycle pulse when result/hi/zero update
//   result, hi, zero    - registered results, held between pulses
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [SW-1:0]    shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero
);

  alu_state_t       state, state_nxt;
  alu_op_t          op;
  logic             accept, is_iter, sc_legal, start;
  logic [WIDTH-1:0] sc_res;
  logic             md_done;
  logic [WIDTH-1:0] md_lo, md_hi;

  // Single-cycle datapath and decode.
  always_comb begin
    op       = alu_op_t'(alu_ctrl);
    is_iter  = 1'b0;
    sc_legal = 1'b1;
    sc_res   = '0;
    case (op)
      OP_AND:  sc_res = rs & rt;
      OP_OR:   sc_res = rs | rt;
      OP_ADD:  sc_res = rs + rt;
      OP_SUB:  sc_res = rs - rt;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(rs) < $signed(rt)};
      OP_NOR:  sc_res = ~(rs | rt);
      OP_SLL:  sc_res = rt << shamt;
      OP_SRL:  sc_res = rt >> shamt;
      OP_MULT, OP_DIVU: begin
        is_iter  = 1'b1;
        sc_legal = 1'b0;
      end
      default: sc_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    start     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && is_iter) begin
          start     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: if (md_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  seq_muldiv #(.WIDTH(WIDTH), .SW(SW)) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mode  (alu_ctrl[0]),
    .a     (rs),
    .b     (rt),
    .done  (md_done),
    .lo    (md_lo),
    .hi    (md_hi)
  );

  // Output registers. Illegal codes still pulse but leave hi alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      hi        <= '0;
      zero      <= 1'b1;
    end else begin
      out_valid <= 1'b0;
      if (accept && !is_iter) begin
        out_valid <= 1'b1;
        result    <= sc_legal ? sc_res : '0;
        zero      <= sc_legal ? (sc_res == '0) : 1'b1;
      end else if (state == BUSY && md_done) begin
        out_valid <= 1'b1;
        result    <= md_lo;
        hi        <= md_hi;
        zero      <= (md_lo == '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] rs, rt;
  logic [4:0]   shamt;
  logic         out_valid;
  logic [W-1:0] result, hi;
  logic         zero;

  int errors = 0;
  int checks = 0;
  int cyc, lows, pulses;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .rs(rs), .rt(rt), .shamt(shamt),
    .out_valid(out_valid), .result(result), .hi(hi), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] sh);
    in_valid = v; alu_ctrl = op; rs = a; rt = b; shamt = sh;
  endtask

  // Runs 40 cycles after acceptance (called right after the accepting
  // negedge drive). Records first pulse cycle, in_ready-low cycles, pulses.
  // Unless hold is set, in_valid drops and operands are scrambled in cycle 1.
  task automatic iter_wait(input bit hold);
    cyc = 0; lows = 0; pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1 && !hold) begin in_valid = 1'b0; rs = '0; rt = '1; end
      if (!in_ready) lows++;
      if (out_valid) begin
        pulses++;
        if (cyc == 0) cyc = i;
        in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 4'b0000, '0, '0, '0);
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    reset = 1'b0;

    // ADD then SUB back-to-back
    @(negedge clk); drive(1'b1, 4'b0010, 32'd5, 32'd7, 5'd0);
    @(negedge clk);
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_result", 64'(result), 64'd12);
    chk("add_zero", 64'(zero), 64'd0);
    drive(1'b1, 4'b0110, 32'd9, 32'd9, 5'd0);
    @(negedge clk);
    chk("sub_valid", 64'(out_valid), 64'd1);
    chk("sub_result", 64'(result), 64'd0);
    chk("sub_zero", 64'(zero), 64'd1);
    drive(1'b1, 4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0);
    @(negedge clk);
    chk("slt_result", 64'(result), 64'd1);
    drive(1'b1, 4'b1110, 32'd0, 32'd1, 5'd31);
    @(negedge clk);
    chk("sll_result", 64'(result), 64'h8000_0000);
    drive(1'b1, 4'b1111, 32'd0, 32'h8000_0000, 5'd31);
    @(negedge clk);
    chk("srl_result", 64'(result), 64'd1);
    drive(1'b1, 4'b1100, 32'hF0F0_0000, 32'h0000_00FF, 5'd0);
    @(negedge clk);
    chk("nor_result", 64'(result), 64'h0F0F_FF00);
    drive(1'b0, 4'b0000, '0, '0, '0);
    @(negedge clk);
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("hold_result", 64'(result), 64'h0F0F_FF00);

    // MULT 0xFFFFFFFF * 2, operands scrambled after acceptance
    drive(1'b1, 4'b1000, 32'hFFFF_FFFF, 32'd2, 5'd0);
    iter_wait(1'b0);
    chk("mult_lows", 64'(lows), 64'd32);
    chk("mult_cycle", 64'(cyc), 64'd33);
    chk("mult_pulses", 64'(pulses), 64'd1);
    chk("mult_lo", 64'(result), 64'hFFFF_FFFE);
    chk("mult_hi", 64'(hi), 64'd1);
    chk("mult_zero", 64'(zero), 64'd0);

    // DIVU 100/7 with in_valid held through BUSY
    drive(1'b1, 4'b1001, 32'd100, 32'd7, 5'd0);
    iter_wait(1'b1);
    chk("divu_cycle", 64'(cyc), 64'd33);
    chk("divu_pulses", 64'(pulses), 64'd1);
    chk("divu_q", 64'(result), 64'd14);
    chk("divu_r", 64'(hi), 64'd2);

    // DIVU 5/0
    drive(1'b1, 4'b1001, 32'd5, 32'd0, 5'd0);
    iter_wait(1'b0);
    chk("div0_cycle", 64'(cyc), 64'd33);
    chk("div0_q", 64'(result), 64'hFFFF_FFFF);
    chk("div0_r", 64'(hi), 64'd5);
    chk("div0_zero", 64'(zero), 64'd0);

    // Reset in cycle 10 of a MULT
    drive(1'b1, 4'b1000, 32'd3, 32'd4, 5'd0);
    @(negedge clk); in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy", 64'(in_ready), 64'd0);
    reset = 1'b1;
    #1;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_zero", 64'(zero), 64'd1);
    @(negedge clk); reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("abort_pulses", 64'(pulses), 64'd0);
    chk("abort_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 4'b0010, 32'd2, 32'd3, 5'd0);
    @(negedge clk);
    chk("post_add_valid", 64'(out_valid), 64'd1);
    chk("post_add_result", 64'(result), 64'd5);
    drive(1'b0, 4'b0000, '0, '0, '0);

    // MULT then illegal code 0101
    @(negedge clk);
    drive(1'b1, 4'b1000, 32'h1234_5678, 32'h100, 5'd0);
    iter_wait(1'b0);
    chk("mult2_lo", 64'(result), 64'h3456_7800);
    chk("mult2_hi", 64'(hi), 64'h12);
    drive(1'b1, 4'b0101, 32'd77, 32'd88, 5'd3);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ill_valid", 64'(out_valid), 64'd1);
    chk("ill_result", 64'(result), 64'd0);
    chk("ill_zero", 64'(zero), 64'd1);
    chk("ill_hi", 64'(hi), 64'h12);
    @(negedge clk);
    chk("ill_pulse_end", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the datapath ALU. It adds OR, SRL, unsigned multiply and unsigned divide on top of the existing single-cycle operation set. Operations enter through a valid/ready handshake and produce a registered, pulsed result. It sits in the EX stage. The pipeline stalls on `in_ready` low while an iterative MULT/DIVU is in flight.

## Interface
- `WIDTH`, 32, datapath width; power of two, 8 or more.
- `SW`, `$clog2(WIDTH)`, shift-amount width (derived; do not override).
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `in_valid` input 1: operation request.
- `in_ready` output 1: block can accept a request this cycle.
- `alu_ctrl` input 4: operation code, listed under Operation.
- `rs` input WIDTH: operand A.
- `rt` input WIDTH: operand B, or the sign-extended immediate.
- `shamt` input SW: shift amount.
- `out_valid` output 1: one-cycle pulse; `result`, `hi` and `zero` are updated.
- `result` output WIDTH: main result; the low product for MULT, the quotient for DIVU.
- `hi` output WIDTH: high product for MULT, remainder for DIVU.
- `zero` output 1: 1 when the registered `result` equals 0.

## Operation
- Codes:
  - AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111: single-cycle.
  - MULT 1000, DIVU 1001: iterative.
  - NOR 1100, SLL 1110, SRL 1111: single-cycle.
- Any other code is illegal: `result` = 0, `zero` = 1, `hi` unchanged, `out_valid` still pulses.
- A request is accepted when `in_valid && in_ready`. Operands are captured at acceptance and later input changes are ignored.
- Arithmetic rules:
  - ADD and SUB wrap modulo 2^WIDTH and produce no overflow flag.
  - SLT is a signed compare; result is 1 or 0, zero-extended.
  - SLL and SRL are logical shifts of `rt` by `shamt`.
- MULT: unsigned `rs*rt`, shift-add, one bit per cycle. The 2·WIDTH product is split: low half to `result`, high half to `hi`.
- DIVU: unsigned restoring division, one quotient bit per cycle. Quotient goes to `result`, remainder to `hi`.
- Divide by zero: quotient is all ones and remainder equals `rs`. No exception is raised.
- Single-cycle ops leave `hi` unchanged.
- State machine:
  - IDLE: `in_ready` = 1.
    - Accept a single-cycle op: load the outputs and pulse `out_valid` next cycle; stay in IDLE.
    - Accept MULT/DIVU: go to BUSY with the counter set to WIDTH.
  - BUSY: `in_ready` = 0. Each cycle runs one iteration and decrements the counter.
    - When the counter reaches 1, write the final `result`/`hi`/`zero`, set `out_valid`, and return to IDLE.
- Iteration counter width is `SW+1`.
- `result`, `hi` and `zero` hold their values between pulses.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `result` = 0, `hi` = 0, `zero` = 1; state is IDLE.
- Single-cycle op latency is 1: accepted at edge 0, `out_valid` is high in cycle 1. Back-to-back acceptance every cycle gives one pulse per cycle.
- MULT/DIVU latency is WIDTH+1: accepted at edge 0, `in_ready` is low in cycles 1..WIDTH, and `out_valid` plus `in_ready` are high in cycle WIDTH+1. A new request can be accepted in that same cycle.
- `zero` is registered in the same edge as `result`. It is never combinationally derived from inputs.
- Reset during BUSY aborts the operation. No `out_valid` pulse follows, and the outputs take their reset values.
- `in_valid` during BUSY is ignored: no queueing, no error.

## Structure
- Shared package `alu_pkg` holds:
  - `alu_op_t`, a 4-bit enum of the codes above;
  - `alu_state_t` (IDLE, BUSY);
  - the `WIDTH` default.
- Sub-module `seq_muldiv` contains:
  - the shared WIDTH×2 accumulator/remainder register, the counter, and the mode select (mul/div);
  - ports `start`, `mode`, `a`, `b`, `done`, `lo`, `hi`.
- The top level contains the single-cycle ops, the output registers and the handshake FSM.

## Test plan
All scenarios use WIDTH = 32.
- ADD 5+7, then SUB 9−9, on consecutive cycles: pulses in cycles 1 and 2, with `result` = 12 / `zero` = 0, then `result` = 0 / `zero` = 1.
- SLT with `rs` = 0xFFFFFFFF, `rt` = 1: `result` = 1. SLL with `rt` = 1, `shamt` = 31: `result` = 0x80000000. SRL with `rt` = 0x80000000, `shamt` = 31: `result` = 1.
- MULT 0xFFFFFFFF × 2: `in_ready` low for exactly 32 cycles, `out_valid` in cycle 33, `result` = 0xFFFFFFFE, `hi` = 0x00000001.
- DIVU 100/7: `result` = 14, `hi` = 2. DIVU 5/0: `result` = 0xFFFFFFFF, `hi` = 5. `in_valid` held during BUSY creates no extra pulses.
- Reset asserted in cycle 10 of a MULT: no `out_valid`, all outputs at reset values, `in_ready` = 1 once reset is released, and a following ADD completes normally.
- Illegal code 0101: pulse in cycle 1, `result` = 0, `zero` = 1, `hi` unchanged from the previous MULT.
